pitch_input_conditioner: RTL
============================

# pitch_input_conditioner

Front-end stage that drives the APU's 8-bit `pitch` input from raw board switches. It synchronises and debounces the switch bus and holds a stable target pitch. Pitch changes are released only at the start of a VGA frame, either as an immediate jump or as a per-frame glide (portamento). This keeps the audio engine from seeing metastable, bouncing or mid-frame pitch changes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000 — consecutive identical synchronised samples required before a switch value is accepted (10 ms at 25 MHz); minimum 2.
- `CNT_W`, 18 — debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `GLIDE_STEP`, 1 — maximum pitch change per frame when gliding; range 1..255.

Ports (`name direction width meaning`):
- `clk` input 1 — single system clock.
- `rst_n` input 1 — reset, synchronous, active-low.
- `sw_in` input 8 — raw asynchronous switch bus.
- `x` input 10 — horizontal position from the sync generator.
- `y` input 10 — vertical position from the sync generator.
- `glide_en` input 1 — 1 = glide toward target, 0 = jump to target (synchronous to `clk`).
- `pitch_out` output 8 — conditioned pitch; connects to the APU `pitch` input.
- `pitch_update` output 1 — one-cycle pulse when `pitch_out` changed on the previous edge.
- `target_pitch` output 8 — current debounced switch value (debug/observation).

## Operation
- Synchroniser: 2-flop chain on all 8 bits; `sync_q` is the second stage. There is no per-bit debounce; the whole bus is debounced as one word.
- Debounce registers: `cand` (8), `cnt` (CNT_W), `stable` (8).
  - `sync_q != cand`: `cand <= sync_q`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, and `cnt` holds (saturates).
  - Else: `cnt <= cnt + 1`.
  - `target_pitch = stable`.
- Frame tick:
  - `fs = (x == 0 && y == 0)`.
  - `fs_d` is `fs` registered.
  - `tick = fs & ~fs_d`, so exactly one tick per frame even if `fs` is held for several cycles.
- Pitch stepper, evaluated on `tick` only:
  - `glide_en == 0`: `pitch_out <= stable`.
  - `glide_en == 1`, `stable > pitch_out`: `pitch_out <= pitch_out + min(GLIDE_STEP, stable - pitch_out)`.
  - `glide_en == 1`, `stable < pitch_out`: `pitch_out <= pitch_out - min(GLIDE_STEP, pitch_out - stable)`.
  - Equal: hold.
- Arithmetic is 8-bit unsigned with difference computed before stepping. It never overshoots the target and never wraps (255→0 or 0→255 is impossible).
- `pitch_update <= tick && (next pitch_out != pitch_out)`.

## Timing
- Reset (`rst_n` low at an edge): sync flops, `cand`, `cnt`, `stable`, `fs_d`, `pitch_out`, `pitch_update` all become 0; `target_pitch` = 0.
- Asserting reset mid-debounce or mid-glide discards all progress at that edge. After release, the first `fs` cycle produces a tick, because `fs_d` = 0.
- Debounce latency: new `sw_in` sampled at edge E0 → `stable` updates at edge E0 + DEBOUNCE_CYCLES + 2, provided `sw_in` is unchanged throughout.
- Any differing sample restarts the count.
- A glitch shorter than DEBOUNCE_CYCLES never reaches `stable`.
- `pitch_out` and `pitch_update` change at the same edge as the tick.
  - `pitch_update` is high for exactly that one following cycle.
  - `pitch_update` is 0 when the tick causes no change.
- Same-edge `stable` update and tick: the stepper uses the old `stable`; the new value applies at the next frame.
- `glide_en` toggled mid-glide: takes effect at the next tick; toggling to 0 jumps straight to target.
- Glide duration: ceil(|target − pitch_out| / GLIDE_STEP) frames.

## Test plan
- Reset/defaults (DEBOUNCE_CYCLES=4): hold `rst_n`=0 with `sw_in`=8'hFF → `pitch_out`=0, `pitch_update`=0, `target_pitch`=0.
- Debounce latency: `sw_in` 0→8'h40 sampled at E0 → `target_pitch`=8'h40 at E0+6, not at E0+5. Then `x`=`y`=0 for one cycle with `glide_en`=0 → `pitch_out`=8'h40 and a one-cycle `pitch_update`.
- Glitch rejection: `sw_in` 8'h40→8'h41 for 3 cycles then back → `target_pitch` stays 8'h40; no `pitch_update` at the next tick.
- Glide (GLIDE_STEP=3, `glide_en`=1): `pitch_out`=10, target 17 → successive ticks give 13, 16, 17, then 17 with no further pulse.
- Tick edge detect: `x`=`y`=0 held for 5 cycles → exactly one step and one `pitch_update` pulse.
- Downward glide without wrap (GLIDE_STEP=255, `pitch_out`=5, target 0): one tick → 0, not 6 or 255. Reset asserted mid-glide → 0 next edge.

Source files
------------

// File: rtl/pitch_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// pitch_input_conditioner_if
//
// Purpose: bundles the board-facing inputs and the APU-facing outputs of the
// pitch input conditioner into one interface.
//
// Signals:
//   sw_in        8  raw asynchronous switch bus
//   x            10 horizontal position from the sync generator
//   y            10 vertical position from the sync generator
//   glide_en     1  1 = glide toward target, 0 = jump to target
//   pitch_out    8  conditioned pitch for the APU
//   pitch_update 1  one-cycle pulse when pitch_out changed
//   target_pitch 8  current debounced switch value
//
// Modports:
//   master - the side that drives switches/sync position and reads results
//   slave  - the conditioner itself
// ---------------------------------------------------------------------------
interface pitch_input_conditioner_if;
    logic [7:0] sw_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       glide_en;
    logic [7:0] pitch_out;
    logic       pitch_update;
    logic [7:0] target_pitch;

    modport master (
        output sw_in,
        output x,
        output y,
        output glide_en,
        input  pitch_out,
        input  pitch_update,
        input  target_pitch
    );

    modport slave (
        input  sw_in,
        input  x,
        input  y,
        input  glide_en,
        output pitch_out,
        output pitch_update,
        output target_pitch
    );
endinterface

// File: rtl/pitch_input_conditioner.sv
// ---------------------------------------------------------------------------
// pitch_input_conditioner
//
// Purpose: drives the APU 8-bit pitch input from raw board switches. The
// switch bus is synchronised (2 flops), debounced as a single word, and held
// as a stable target. Pitch changes are only released on the first cycle of
// a VGA frame (x == 0 && y == 0), either as an immediate jump or as a
// bounded per-frame glide toward the target.
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  synchronous active-low reset
//   bus    slave modport of pitch_input_conditioner_if
//                 (sw_in, x, y, glide_en in; pitch_out, pitch_update,
//                  target_pitch out)
//
// Parameters:
//   DEBOUNCE_CYCLES  identical synchronised samples needed to accept a value
//   CNT_W            debounce counter width, 2^CNT_W > DEBOUNCE_CYCLES
//   GLIDE_STEP       largest pitch change per frame while gliding (1..255)
// ---------------------------------------------------------------------------
module pitch_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int GLIDE_STEP      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pitch_input_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       STEP     = 8'(GLIDE_STEP);

    // One glide step from cur toward tgt. The distance is formed before the
    // step is applied, so the result never passes the target and never wraps.
    function automatic logic [7:0] glide_step(input logic [7:0] cur,
                                              input logic [7:0] tgt);
        logic [7:0] diff;
        logic [7:0] res;
        res = cur;
        if (tgt > cur) begin
            diff = tgt - cur;
            res  = cur + ((diff < STEP) ? diff : STEP);
        end else if (tgt < cur) begin
            diff = cur - tgt;
            res  = cur - ((diff < STEP) ? diff : STEP);
        end
        return res;
    endfunction

    logic [7:0]       sync_p0;
    logic [7:0]       sync_q;
    logic [7:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       stable;
    logic             fs;
    logic             fs_d;
    logic             tick;
    logic [7:0]       pitch_q;
    logic [7:0]       next_pitch;
    logic             pitch_update_q;

    // ---- stage: two-flop synchroniser on the raw switch bus ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 8'd0;
            sync_q  <= 8'd0;
        end else begin
            sync_p0 <= bus.sw_in;
            sync_q  <= sync_p0;
        end
    end

    // ---- stage: whole-word debounce ----
    // Any change of the synchronised word restarts the count; once the count
    // reaches its last value it saturates so stable is simply re-written
    // with the same candidate until the next change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand   <= 8'd0;
            cnt    <= '0;
            stable <= 8'd0;
        end else if (sync_q != cand) begin
            cand <= sync_q;
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= cand;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---- stage: frame-start edge detect ----
    // fs can stay high for several cycles while x/y sit at 0; only its rising
    // edge counts. fs_d resets low so the first frame after reset ticks.
    assign fs   = (bus.x == 10'd0) && (bus.y == 10'd0);
    assign tick = fs & ~fs_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fs_d <= 1'b0;
        end else begin
            fs_d <= fs;
        end
    end

    // ---- stage: per-frame pitch stepper ----
    // stable is read as registered, so a debounce update landing on the
    // same edge as a tick only takes effect on the following frame.
    always_comb begin
        next_pitch = pitch_q;
        if (tick) begin
            if (bus.glide_en) begin
                next_pitch = glide_step(pitch_q, stable);
            end else begin
                next_pitch = stable;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pitch_q        <= 8'd0;
            pitch_update_q <= 1'b0;
        end else begin
            pitch_q        <= next_pitch;
            pitch_update_q <= tick && (next_pitch != pitch_q);
        end
    end

    assign bus.pitch_out    = pitch_q;
    assign bus.pitch_update = pitch_update_q;
    assign bus.target_pitch = stable;

endmodule
